// File: rtl/golden_nonce_queue_pkg.sv
// Shared definitions for golden_nonce_queue: transmit FSM encodings,
// the default pipeline-offset formula and a saturating counter helper.
package golden_nonce_queue_pkg;

    // Transmit handshake states toward serial_transmit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

    // Unroll factor of the hasher this queue is normally paired with.
    localparam int unsigned DEFAULT_LOOP_LOG2 = 2;

    // Number of nonce increments between the hasher sampling a nonce and
    // raising its golden strobe: (1 << (7 - LOOP_LOG2)) + 1.
    function automatic logic [31:0] nonce_offset_for(input int unsigned loop_log2);
        return 32'((1 << (7 - loop_log2)) + 1);
    endfunction

    // 32-bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] base, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/golden_fifo_2w1r.sv
// Nonce storage for golden_nonce_queue: up to two writes and one read per
// cycle. Writes arrive compacted (wr_data0 is always the older entry), the
// head is read combinationally and the occupancy is kept in a register.
// The caller guarantees wr_cnt never exceeds the free slots (counting a
// same-cycle pop as free) and never pops when empty.
module golden_fifo_2w1r #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            wr_cnt,
    input  logic [WIDTH-1:0]      wr_data0,
    input  logic [WIDTH-1:0]      wr_data1,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   lvl_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_p1;
    lvl_t             level_q, level_d;

    // Pointer and level arithmetic; pointers wrap naturally at DEPTH.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path first, so no latch is inferred.
        wr_ptr_p1 = wr_ptr_q + ptr_t'(1);
        wr_ptr_d  = wr_ptr_q + ptr_t'(wr_cnt);
        rd_ptr_d  = rd_ptr_q + ptr_t'(rd_en);
        level_d   = level_q + lvl_t'(wr_cnt) - lvl_t'(rd_en);
    end

    // Control registers: pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write: first entry at the write pointer, second one slot after.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the level register alone decides which entries are valid.
        if (wr_cnt != 2'd0) begin
            mem_q[wr_ptr_q] <= wr_data0;
        end
        if (wr_cnt == 2'd2) begin
            mem_q[wr_ptr_p1] <= wr_data1;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

endmodule

// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue: collects golden-ticket hits from both hasher lanes,
// removes the hasher pipeline offset from the nonce and queues the results
// for serial_transmit, one word per send/busy handshake.
// Optional build macro GOLDEN_STATS_EN adds saturating hit/drop counters
// on ports hits_total and hits_dropped.
module golden_nonce_queue
    import golden_nonce_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 3,
    parameter logic [31:0] NONCE_OFFSET = nonce_offset_for(DEFAULT_LOOP_LOG2)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                golden_0,
    input  logic [31:0]         nonce_0,
    input  logic                golden_1,
    input  logic [31:0]         nonce_1,
    input  logic                serial_busy,
    output logic                serial_send,
    output logic [31:0]         word,
    output logic                overflow,
    output logic [DEPTH_LOG2:0] fifo_level
`ifdef GOLDEN_STATS_EN
    ,
    output logic [31:0]         hits_total,
    output logic [31:0]         hits_dropped
`endif
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    // One bit wider than the level so DEPTH plus a pop fits.
    typedef logic [DEPTH_LOG2+1:0] free_t;

    tx_state_e   state_q, state_d;
    logic [31:0] word_q, word_d;

    logic [31:0] entry_0, entry_1;
    logic [31:0] head;
    logic        pop;
    free_t       free_slots;
    logic        keep_0, keep_1;
    logic [1:0]  wr_cnt;
    logic [31:0] wr_data0, wr_data1;

    golden_fifo_2w1r #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_cnt   (wr_cnt),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rd_en    (pop),
        .rd_data  (head),
        .level    (fifo_level)
    );

    // Capture: offset correction, slot allocation (lane 0 wins) and drop flag.
    always_comb begin
        entry_0    = nonce_0 - NONCE_OFFSET;
        entry_1    = nonce_1 - NONCE_OFFSET;
        // The head is popped on the edge where the link acknowledges it.
        pop        = (state_q == ST_REQ) && serial_busy;
        free_slots = free_t'(DEPTH) - free_t'(fifo_level) + free_t'(pop);
        keep_0     = golden_0 && (free_slots != '0);
        keep_1     = golden_1 && (free_slots > free_t'(keep_0));
        wr_cnt     = {1'b0, keep_0} + {1'b0, keep_1};
        // Compact the writes so the FIFO always sees the older entry first.
        wr_data0   = keep_0 ? entry_0 : entry_1;
        wr_data1   = entry_1;
        overflow   = (golden_0 && !keep_0) || (golden_1 && !keep_1);
    end

    // Transmit FSM state and presented word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    // Transmit FSM next state: load in IDLE, request until acked, wait for the link to free.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if ((fifo_level != '0) && !serial_busy) begin
                    word_d  = head;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (serial_busy) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!serial_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Send is decoded straight from the state register, so reset clears it at once.
    assign serial_send = (state_q == ST_REQ);
    assign word        = word_q;

`ifdef GOLDEN_STATS_EN
    logic [31:0] hits_total_q, hits_total_d;
    logic [31:0] hits_dropped_q, hits_dropped_d;
    logic [1:0]  n_hits, n_dropped;

    // Statistics next values: every strobe counts, drops counted separately.
    always_comb begin
        n_hits         = {1'b0, golden_0} + {1'b0, golden_1};
        n_dropped      = {1'b0, golden_0 && !keep_0} + {1'b0, golden_1 && !keep_1};
        hits_total_d   = sat_add32(hits_total_q, n_hits);
        hits_dropped_d = sat_add32(hits_dropped_q, n_dropped);
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hits_total_q   <= '0;
            hits_dropped_q <= '0;
        end else begin
            hits_total_q   <= hits_total_d;
            hits_dropped_q <= hits_dropped_d;
        end
    end

    assign hits_total   = hits_total_q;
    assign hits_dropped = hits_dropped_q;
`endif

endmodule

// File: tb/tb_golden_nonce_queue.sv
// Self-checking bench for golden_nonce_queue. Expected words are pushed to a
// scoreboard when hits are driven and compared when the model serial link
// accepts a send. Build with GOLDEN_STATS_EN to also check the counters.
module tb_golden_nonce_queue;

    localparam logic [31:0] OFF = 32'd33;

    logic        clk;
    logic        reset_n;
    logic        golden_0, golden_1;
    logic [31:0] nonce_0, nonce_1;
    logic        serial_busy;
    logic        serial_send;
    logic [31:0] word;
    logic        overflow;
    logic [3:0]  fifo_level;
`ifdef GOLDEN_STATS_EN
    logic [31:0] hits_total, hits_dropped;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];
    logic        force_busy = 1'b0;
    logic        ovf_expected = 1'b0;
    int          busy_cnt = 0;
    logic [31:0] exp_total = '0;
    logic [31:0] exp_dropped = '0;

    golden_nonce_queue dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .golden_0     (golden_0),
        .nonce_0      (nonce_0),
        .golden_1     (golden_1),
        .nonce_1      (nonce_1),
        .serial_busy  (serial_busy),
        .serial_send  (serial_send),
        .word         (word),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
`ifdef GOLDEN_STATS_EN
        ,
        .hits_total   (hits_total),
        .hits_dropped (hits_dropped)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: drive one strobe cycle, record kept hits, check overflow.
    task automatic strobe(input logic g0, input logic [31:0] n0,
                          input logic g1, input logic [31:0] n1,
                          input logic k0, input logic k1);
        logic exp_ovf;
        exp_ovf  = (g0 && !k0) || (g1 && !k1);
        golden_0 = g0; nonce_0 = n0;
        golden_1 = g1; nonce_1 = n1;
        ovf_expected = exp_ovf;
        if (k0) sb.push_back(n0 - OFF);
        if (k1) sb.push_back(n1 - OFF);
        exp_total   = exp_total + 32'(g0) + 32'(g1);
        exp_dropped = exp_dropped + 32'(g0 && !k0) + 32'(g1 && !k1);
        @(negedge clk); #2;
        check("overflow", 32'(overflow), 32'(exp_ovf));
        @(posedge clk); #1;
        golden_0 = 1'b0; golden_1 = 1'b0;
        ovf_expected = 1'b0;
    endtask

    // Run until the scoreboard and FIFO are empty and the link is idle.
    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || fifo_level != 4'd0 || serial_send || serial_busy) && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 500) check({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
        check({tag, "_level_empty"}, 32'(fifo_level), 32'd0);
    endtask

    // Wait (bounded) for serial_send to be high, returning at posedge+1.
    task automatic wait_send(input string tag);
        int cyc;
        cyc = 0;
        while (!serial_send && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 50) check({tag, "_send_timeout"}, 32'(serial_send), 32'd1);
    endtask

    // Model serial link: acknowledges a send with a 3-cycle busy pulse.
    initial begin
        logic [31:0] exp;
        serial_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                serial_busy = 1'b0;
                busy_cnt = 0;
            end else if (force_busy) begin
                serial_busy = 1'b1;
            end else if (busy_cnt != 0) begin
                busy_cnt--;
                if (busy_cnt == 0) serial_busy = 1'b0;
            end else if (serial_send && !serial_busy) begin
                if (sb.size() == 0) begin
                    check("spurious_send", 32'(serial_send), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("word", word, exp);
                end
                serial_busy = 1'b1;
                busy_cnt = 3;
            end else begin
                serial_busy = 1'b0;
            end
        end
    end

    // Overflow must only ever appear when the stimulus expects a drop.
    initial begin
        forever begin
            @(negedge clk); #2;
            if (overflow && !ovf_expected) check("overflow_unexpected", 32'(overflow), 32'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        golden_0 = 1'b0; golden_1 = 1'b0;
        nonce_0  = '0;   nonce_1  = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_send", 32'(serial_send), 32'd0);
        check("rst_word", word, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1. Single hit: write edge, then load edge, then send.
        strobe(1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk); #2;
        check("t1_send_after_write", 32'(serial_send), 32'd0);
        check("t1_level_one", 32'(fifo_level), 32'd1);
        @(negedge clk); #2;
        check("t1_send_high", 32'(serial_send), 32'd1);
        check("t1_word", word, 32'h0000_0FDF);
        @(negedge clk); #2;
        check("t1_level_after_pop", 32'(fifo_level), 32'd0);
        check("t1_send_dropped", 32'(serial_send), 32'd0);
        @(posedge clk); #1;
        wait_drain("t1");

        // 2. Simultaneous hits keep lane order.
        strobe(1'b1, 32'h0000_0100, 1'b1, 32'h8000_0100, 1'b1, 1'b1);
        @(negedge clk); #2;
        check("t2_level_two", 32'(fifo_level), 32'd2);
        @(posedge clk); #1;
        wait_drain("t2");

        // 3. Busy link: fill to depth, ninth hit dropped, then drain in order.
        force_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) strobe(1'b1, 32'h0000_2000 + 32'(i) * 32'h111, 1'b0, 32'h0, 1'b1, 1'b0);
            else            strobe(1'b0, 32'h0, 1'b1, 32'h0000_2000 + 32'(i) * 32'h111, 1'b0, 1'b1);
        end
        @(negedge clk); #2;
        check("t3_level_full", 32'(fifo_level), 32'd8);
        check("t3_no_send", 32'(serial_send), 32'd0);
        @(posedge clk); #1;
        strobe(1'b1, 32'h0000_9999, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk); #2;
        check("t3_level_still_full", 32'(fifo_level), 32'd8);
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_drain("t3");

        // 4. Wrap below zero on both lanes.
        strobe(1'b0, 32'h0, 1'b1, 32'h0000_0005, 1'b0, 1'b1);
        wait_drain("t4a");
        strobe(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b1, 1'b0);
        wait_drain("t4b");

        // 5. Seven queued, dual hit in the same cycle as the pop.
        force_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 7; i++) begin
            strobe(1'b1, 32'h0000_5000 + 32'(i), 1'b0, 32'h0, 1'b1, 1'b0);
        end
        @(negedge clk); #2;
        check("t5_level_seven", 32'(fifo_level), 32'd7);
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_send("t5");
        strobe(1'b1, 32'h0000_6000, 1'b1, 32'h0000_7000, 1'b1, 1'b1);
        @(negedge clk); #2;
        check("t5_level_full", 32'(fifo_level), 32'd8);
        @(posedge clk); #1;
        wait_drain("t5");

`ifdef GOLDEN_STATS_EN
        check("stats_total", hits_total, exp_total);
        check("stats_dropped", hits_dropped, exp_dropped);
`endif

        // 6. Reset while a send request is up.
        force_busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        strobe(1'b1, 32'h0000_A000, 1'b1, 32'h0000_B000, 1'b1, 1'b1);
        force_busy = 1'b0;
        wait_send("t6");
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_send_async", 32'(serial_send), 32'd0);
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_word", word, 32'd0);
`ifdef GOLDEN_STATS_EN
        check("t6_stats_total", hits_total, 32'd0);
        check("t6_stats_dropped", hits_dropped, 32'd0);
`endif
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        strobe(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        wait_drain("t6_recover");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
